m68k_irq_ctrl: RTL and testbench

// - Parametrised 68000 interrupt controller for the F2 top level; replaces the fixed vblank/DMA/save-request IPL logic.
// - Latches NUM_SRC interrupt sources, each with its own IPL level and edge/level mode.
// - Drives the CPU IPLn lines and asserts VPAn during IACK cycles for autovectoring.
// - Clears each pending source on the matching IACK cycle.

---
 rtl/irq_ctrl_pkg.sv | 34 +++
 rtl/irq_src_sync.sv | 43 ++++
 rtl/m68k_irq_ctrl.sv | 139 +++++++++++++
 tb/tb_m68k_irq_ctrl.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/irq_ctrl_pkg.sv
// Shared types and helpers for the 68000 interrupt controller.
package irq_ctrl_pkg;

  localparam logic [2:0] FC_IACK = 3'b111;

  typedef logic [2:0] ipl_t;

  typedef enum logic {
    IACK_IDLE,
    IACK_SEEN
  } iack_state_t;

  typedef struct packed {
    logic       valid;
    logic [2:0] index;
    ipl_t       level;
  } prio_t;

  // Highest level wins; a strict compare keeps the lowest index on ties.
  // Level 0 can never beat the initial best, so disabled sources never win.
  function automatic prio_t prio_winner(input logic [7:0] pend, input logic [23:0] levels);
    prio_t w;
    w = '0;
    for (int i = 0; i < 8; i++) begin
      if (pend[i] && (levels[3*i+:3] > w.level)) begin
        w.valid = 1'b1;
        w.index = 3'(i);
        w.level = levels[3*i+:3];
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/irq_src_sync.sv
// One interrupt source: synchroniser chain, polarity fix-up, rising-edge detect.
module irq_src_sync #(
  parameter int SYNC_STAGES = 2,
  parameter bit FALLING     = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic src,
  output logic active,
  output logic rise
);

  logic synced;
  logic active_d;

  if (SYNC_STAGES == 0) begin : g_nosync
    assign synced = src;
  end else begin : g_sync
    logic [SYNC_STAGES-1:0] sync_q;
    // Shift the raw input through the chain; reset to the inactive raw level
    // so a falling-active source does not look asserted coming out of reset.
    always_ff @(posedge clk) begin
      if (reset) begin
        sync_q <= {SYNC_STAGES{FALLING}};
      end else begin
        sync_q[0] <= src;
        for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
      end
    end
    assign synced = sync_q[SYNC_STAGES-1];
  end

  assign active = synced ^ FALLING;

  // Remember the previous active value for edge detection.
  always_ff @(posedge clk) begin
    if (reset) active_d <= 1'b0;
    else       active_d <= active;
  end

  assign rise = active & ~active_d;

endmodule

// File: rtl/m68k_irq_ctrl.sv
// 68000 interrupt controller: latches sources, drives IPLn, autovectors IACK.
// Optional register file enabled by the macro M68K_IRQ_CTRL_REGS_EN.
// Handshake: the CPU bus has no valid/ready; an IACK cycle is valid while
// fc==FC_IACK with AS and LDS low, and ends when AS returns high.
module m68k_irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int                   NUM_SRC        = 4,
  parameter logic [NUM_SRC*3-1:0] SRC_LEVEL      = {3'd7, 3'd6, 3'd5, 3'd4},
  parameter logic [NUM_SRC-1:0]   SRC_LEVEL_MODE = '0,
  parameter logic [NUM_SRC-1:0]   SRC_FALLING    = '0,
  parameter int                   SYNC_STAGES    = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] src_in,
  input  logic [2:0]         cpu_fc,
  input  logic [2:0]         cpu_addr,
  input  logic               cpu_as_n,
  input  logic               cpu_lds_n,
  output ipl_t               ipl_n,
  output logic               vpa_n,
  output logic [NUM_SRC-1:0] pending,
  input  logic               reg_cs_n,
  input  logic               reg_rw,
  input  logic               reg_addr,
  input  logic [15:0]        reg_din,
  output logic [15:0]        reg_dout
);

  logic [NUM_SRC-1:0] active, rise, enabled, is_edge;
  logic [NUM_SRC-1:0] mask, w1c, clr, pending_nxt;
  logic               iack, iack_first;
  iack_state_t        iack_state, iack_state_nxt;
  prio_t              win;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    irq_src_sync #(
      .SYNC_STAGES(SYNC_STAGES),
      .FALLING    (SRC_FALLING[i])
    ) u_sync (
      .clk   (clk),
      .reset (reset),
      .src   (src_in[i]),
      .active(active[i]),
      .rise  (rise[i])
    );
    assign enabled[i] = (SRC_LEVEL[3*i+:3] != 3'd0);
    assign is_edge[i] = enabled[i] & ~SRC_LEVEL_MODE[i];
  end

  assign iack  = (cpu_fc == FC_IACK) & ~cpu_as_n & ~cpu_lds_n;
  assign vpa_n = ~(iack & ~reset);

  // IACK tracking state register.
  always_ff @(posedge clk) begin
    if (reset) iack_state <= IACK_IDLE;
    else       iack_state <= iack_state_nxt;
  end

  // IACK next state; iack_first marks the single clk a clear may apply.
  always_comb begin
    iack_state_nxt = iack_state;
    iack_first     = 1'b0;
    case (iack_state)
      IACK_IDLE: if (iack) begin
        iack_first     = 1'b1;
        iack_state_nxt = IACK_SEEN;
      end
      IACK_SEEN: if (cpu_as_n) iack_state_nxt = IACK_IDLE;
      default:   iack_state_nxt = IACK_IDLE;
    endcase
  end

  // Pick the lowest-index pending edge source at the acknowledged level.
  always_comb begin
    clr = '0;
    if (iack_first) begin
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
        if (pending[i] && is_edge[i] && (SRC_LEVEL[3*i+:3] == cpu_addr)) begin
          clr    = '0;
          clr[i] = 1'b1;
        end
      end
    end
  end

  // Next pending: level sources follow input, edge sources latch; set wins.
  always_comb begin
    pending_nxt = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (!enabled[i])           pending_nxt[i] = 1'b0;
      else if (SRC_LEVEL_MODE[i]) pending_nxt[i] = active[i];
      else pending_nxt[i] = (pending[i] & ~clr[i] & ~w1c[i]) | rise[i];
    end
  end

  assign win = prio_winner(8'(pending & mask), 24'(SRC_LEVEL));

  // Pending flags and registered IPL, one clk behind pending.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending <= '0;
      ipl_n   <= 3'b111;
    end else begin
      pending <= pending_nxt;
      ipl_n   <= win.valid ? ~win.level : 3'b111;
    end
  end

  logic unused_win;
  assign unused_win = ^win.index;

`ifdef M68K_IRQ_CTRL_REGS_EN
  logic reg_wr;
  assign reg_wr = ~reg_cs_n & ~reg_rw;
  assign w1c    = (reg_wr && reg_addr) ? (reg_din[NUM_SRC-1:0] & is_edge) : '0;

  // Mask register, all sources enabled out of reset.
  always_ff @(posedge clk) begin
    if (reset)                 mask <= '1;
    else if (reg_wr && !reg_addr) mask <= reg_din[NUM_SRC-1:0];
  end

  // Combinational read port, zero when not selected for read.
  always_comb begin
    reg_dout = 16'd0;
    if (!reset && !reg_cs_n && reg_rw) reg_dout = reg_addr ? 16'(pending) : 16'(mask);
  end
`else
  assign mask     = '1;
  assign w1c      = '0;
  assign reg_dout = 16'd0;

  logic unused_regs;
  assign unused_regs = ^{reg_cs_n, reg_rw, reg_addr, reg_din};
`endif

endmodule

// File: tb/tb_m68k_irq_ctrl.sv
// Randomised bench for m68k_irq_ctrl against a cycle-level reference model.
module tb_m68k_irq_ctrl;

  localparam int              N      = 5;
  localparam logic [N*3-1:0]  LEVELS = {3'd0, 3'd5, 3'd7, 3'd6, 3'd5};
  localparam logic [N-1:0]    LMODE  = 5'b00010;
  localparam logic [N-1:0]    FALL   = 5'b01000;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] src_in = FALL;
  logic [2:0]   cpu_fc = 3'd0, cpu_addr = 3'd0;
  logic         cpu_as_n = 1'b1, cpu_lds_n = 1'b1;
  logic [2:0]   ipl_n;
  logic         vpa_n;
  logic [N-1:0] pending;
  logic         reg_cs_n = 1'b1, reg_rw = 1'b1, reg_addr = 1'b0;
  logic [15:0]  reg_din = 16'd0;
  logic [15:0]  reg_dout;

  int n_checks = 0;
  int n_fail   = 0;

  m68k_irq_ctrl #(
    .NUM_SRC       (N),
    .SRC_LEVEL     (LEVELS),
    .SRC_LEVEL_MODE(LMODE),
    .SRC_FALLING   (FALL),
    .SYNC_STAGES   (2)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .src_in   (src_in),
    .cpu_fc   (cpu_fc),
    .cpu_addr (cpu_addr),
    .cpu_as_n (cpu_as_n),
    .cpu_lds_n(cpu_lds_n),
    .ipl_n    (ipl_n),
    .vpa_n    (vpa_n),
    .pending  (pending),
    .reg_cs_n (reg_cs_n),
    .reg_rw   (reg_rw),
    .reg_addr (reg_addr),
    .reg_din  (reg_din),
    .reg_dout (reg_dout)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int lvl(input int i);
    return int'(LEVELS[3*i+:3]);
  endfunction

  // reference model state
  logic [N-1:0] hist[$];
  logic [N-1:0] m_pend = '0;
  logic [N-1:0] m_mask = '1;
  logic [2:0]   m_ipl = 3'b111;
  bit           m_seen = 0;
  bit           live = 0;
  logic [N+2:0] exp_q[$];

  // Model: an input sampled at edge k is seen as active during the cycle
  // after edge k+1; a new active edge pends, the first IACK clk clears.
  always @(posedge clk) begin : model
    logic [N-1:0] a_cur, a_prev, nxt;
    int best, clr_idx;
    bit iack, do_w1c;
    if (reset) begin
      m_pend = '0; m_mask = '1; m_ipl = 3'b111; m_seen = 0;
      hist.delete();
      repeat (3) hist.push_back(FALL);
    end else begin
      a_cur  = hist[1] ^ FALL;
      a_prev = hist[2] ^ FALL;
      best = 0;
      for (int i = 0; i < N; i++)
        if (m_pend[i] && m_mask[i] && lvl(i) > best) best = lvl(i);
      iack = (cpu_fc == 3'b111) && !cpu_as_n && !cpu_lds_n;
      clr_idx = -1;
      if (iack && !m_seen)
        for (int i = N - 1; i >= 0; i--)
          if (m_pend[i] && !LMODE[i] && lvl(i) != 0 && lvl(i) == int'(cpu_addr)) clr_idx = i;
      do_w1c = 0;
`ifdef M68K_IRQ_CTRL_REGS_EN
      do_w1c = !reg_cs_n && !reg_rw && reg_addr;
`endif
      for (int i = 0; i < N; i++) begin
        if (lvl(i) == 0) nxt[i] = 1'b0;
        else if (LMODE[i]) nxt[i] = a_cur[i];
        else begin
          nxt[i] = m_pend[i];
          if (clr_idx == i) nxt[i] = 1'b0;
          if (do_w1c && reg_din[i]) nxt[i] = 1'b0;
          if (a_cur[i] && !a_prev[i]) nxt[i] = 1'b1;
        end
      end
`ifdef M68K_IRQ_CTRL_REGS_EN
      if (!reg_cs_n && !reg_rw && !reg_addr) m_mask = reg_din[N-1:0];
`endif
      if (!m_seen && iack) m_seen = 1;
      else if (m_seen && cpu_as_n) m_seen = 0;
      m_ipl  = ~3'(best);
      m_pend = nxt;
      hist.push_front(src_in);
      void'(hist.pop_back());
    end
    exp_q.push_back({m_ipl, m_pend});
    live = 1;
  end

  // scoreboard: compare every cycle on the falling edge
  always @(negedge clk) begin : scoreboard
    logic [N+2:0] e;
    logic [15:0]  exp_dout;
    bit           iack_now;
    if (live && exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check_val("pending", 16'(pending), 16'(e[N-1:0]));
      check_val("ipl_n", 16'(ipl_n), 16'(e[N+2:N]));
      iack_now = (cpu_fc == 3'b111) && !cpu_as_n && !cpu_lds_n && !reset;
      check_val("vpa_n", 16'(vpa_n), 16'(!iack_now));
      exp_dout = 16'd0;
`ifdef M68K_IRQ_CTRL_REGS_EN
      if (!reset && !reg_cs_n && reg_rw) exp_dout = reg_addr ? 16'(m_pend) : 16'(m_mask);
`endif
      check_val("reg_dout", reg_dout, exp_dout);
    end
  end

  // driver tasks
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic iack_cycle(input logic [2:0] addr, input int hold);
    cpu_fc = 3'b111; cpu_addr = addr; cpu_as_n = 1'b0; cpu_lds_n = 1'b0;
    step(hold);
    cpu_as_n = 1'b1; cpu_lds_n = 1'b1; cpu_fc = 3'd0;
    step(1);
  endtask

  task automatic reg_write(input logic a, input logic [15:0] d);
    reg_cs_n = 1'b0; reg_rw = 1'b0; reg_addr = a; reg_din = d;
    step(1);
    reg_cs_n = 1'b1; reg_rw = 1'b1;
  endtask

  task automatic reg_read(input logic a);
    reg_cs_n = 1'b0; reg_rw = 1'b1; reg_addr = a;
    step(1);
    reg_cs_n = 1'b1;
  endtask

  initial begin
    step(3);
    @(negedge clk); #1;
    check_val("rst_ipl", 16'(ipl_n), 16'h7);
    check_val("rst_pending", 16'(pending), 16'h0);
    check_val("rst_vpa", 16'(vpa_n), 16'h1);
    check_val("rst_dout", reg_dout, 16'h0);
    step(1);
    reset = 1'b0;
    step(3);

    // single edge source, then a directed latency check
    src_in[0] = 1'b1;
    step(3);
    check_val("edge_latency_pend", 16'(pending), 16'h01);
    step(1);
    check_val("edge_latency_ipl", 16'(ipl_n), 16'(3'b010));
    // falling source at same level; IACK clears lowest index only
    src_in[3] = 1'b0;
    step(5);
    iack_cycle(3'd5, 20);
    step(3);
    iack_cycle(3'd5, 3);
    // L7 over L5, long IACK clears once
    src_in[0] = 1'b0; src_in[3] = 1'b1;
    step(3);
    src_in[0] = 1'b1; src_in[2] = 1'b1;
    step(6);
    iack_cycle(3'd7, 20);
    step(3);
    // new edge on src 2 in the clk its IACK clear lands
    src_in[2] = 1'b0;
    step(4);
    src_in[2] = 1'b1;
    step(1);
    cpu_fc = 3'b111; cpu_addr = 3'd7; cpu_as_n = 1'b0; cpu_lds_n = 1'b0;
    step(1);
    cpu_as_n = 1'b1; cpu_lds_n = 1'b1; cpu_fc = 3'd0;
    step(3);
    // level source ignores IACK, follows input
    src_in[1] = 1'b1;
    step(5);
    iack_cycle(3'd6, 4);
    src_in[1] = 1'b0;
    step(5);
    // spurious IACK and a disabled source
    iack_cycle(3'd3, 3);
    src_in[4] = 1'b1;
    step(5);
    src_in[4] = 1'b0;

`ifdef M68K_IRQ_CTRL_REGS_EN
    reg_write(1'b0, 16'h001b);
    step(3);
    reg_read(1'b0);
    reg_read(1'b1);
    reg_write(1'b1, 16'h0004);
    step(2);
    reg_write(1'b0, 16'hffff);
    step(2);
`endif

    // randomised traffic
    for (int it = 0; it < 60; it++) begin
      case ($urandom_range(0, 3))
        0: src_in[$urandom_range(0, N - 1)] ^= 1'b1;
        1: iack_cycle(3'($urandom_range(3, 7)), $urandom_range(1, 5));
`ifdef M68K_IRQ_CTRL_REGS_EN
        2: begin
          if ($urandom_range(0, 1) == 1) reg_read(1'($urandom_range(0, 1)));
          else reg_write(1'($urandom_range(0, 1)), 16'($urandom_range(0, 31)));
        end
`endif
        default: src_in = src_in ^ N'($urandom_range(0, 31));
      endcase
      step($urandom_range(0, 4));
    end

    // reset in the middle of an IACK cycle
    src_in = FALL | 5'b00101;
    step(6);
    cpu_fc = 3'b111; cpu_addr = 3'd5; cpu_as_n = 1'b0; cpu_lds_n = 1'b0;
    step(2);
    reset = 1'b1;
    step(1);
    check_val("rst_iack_vpa", 16'(vpa_n), 16'h1);
    check_val("rst_iack_ipl", 16'(ipl_n), 16'h7);
    check_val("rst_iack_pend", 16'(pending), 16'h0);
    cpu_as_n = 1'b1; cpu_lds_n = 1'b1; cpu_fc = 3'd0;
    step(1);
    reset = 1'b0;
    step(8);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
